// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t  - one instruction-queue entry {pc, instr, adel}
//   fetch_state_t  - request FSM state {IDLE, REQ, WAIT}
//   ibus_req_t     - I-bus request  {valid, addr}
//   ibus_resp_t    - I-bus response {addr_ok, data_ok, data}
//   DEFAULT_RESET_PC - power-on fetch address
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with a registered head.
//   clk, resetn        - clock, asynchronous active-low reset
//   push, push_data    - enqueue one entry (ignored when full unless popping)
//   pop                - drop the head entry (ignored when empty)
//   flush              - empty the queue; takes priority over push/pop
//   count              - number of stored entries
//   head_valid, head   - registered head entry; head holds its last value
//                        while the queue is empty
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output fetch_entry_t             head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   fetch_entry_t  head_q, head_d;
   logic          head_valid_q, head_valid_d;
   logic          do_push, do_pop;

   always_comb begin
      do_pop       = pop && !flush && (count_q != '0);
      do_push      = push && !flush && ((count_q != FULL_CNT) || do_pop);
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_d       = head_q;
      head_valid_d = head_valid_q;

      if (flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         head_valid_d = 1'b0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;

         head_valid_d = (count_d != '0);
         // With no surviving older entry the new head is the word being
         // pushed right now; it is not in mem_q yet.
         if (count_d != '0) begin
            if ((count_q == '0) || ((count_q == CW'(1)) && do_pop))
               head_d = push_data;
            else
               head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_q       <= '0;
         head_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign count      = count_q;
   assign head_valid = head_valid_q;
   assign head       = head_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage. Owns the fetch PC, issues at most one I-bus
// request at a time and buffers returned words in a fetch_queue.
//   clk, resetn                 - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc - redirect from later stages (highest priority)
//   deq_ready                   - decode accepts the head entry
//   out_valid/out_pc/out_instr/out_adel - head entry of the queue
//   ireq                        - I-bus request {valid, addr}
//   iresp                       - I-bus response {addr_ok, data_ok, data}
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned fetch PCs are not
// sent to the bus; a single adel entry is queued instead and fetching stops
// until the next redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [31:0] PC_STEP     = 32'd4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        deq_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_adel,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp
);

   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(QUEUE_DEPTH);

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          drop_q, drop_d;
   ibus_req_t     ireq_q, ireq_d;
`ifdef FETCH_ALIGN_CHECK_EN
   logic          halt_q, halt_d;
`endif

   logic          q_push, q_pop, q_flush, q_head_valid;
   fetch_entry_t  q_push_data, q_head;
   logic [CW-1:0] q_count, cnt_next;
   logic          done, issue_pt, may_issue;

   fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk        (clk),
      .resetn     (resetn),
      .push       (q_push),
      .push_data  (q_push_data),
      .pop        (q_pop),
      .flush      (q_flush),
      .count      (q_count),
      .head_valid (q_head_valid),
      .head       (q_head)
   );

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_d      = drop_q;
      ireq_d      = ireq_q;
`ifdef FETCH_ALIGN_CHECK_EN
      halt_d      = halt_q;
`endif
      q_push      = 1'b0;
      q_push_data = '{pc: fetch_pc_q, instr: iresp.data, adel: 1'b0};
      q_pop       = q_head_valid && deq_ready && !redirect_valid;
      q_flush     = redirect_valid;
      done        = 1'b0;
      issue_pt    = 1'b0;

      unique case (state_q)
         IDLE: issue_pt = 1'b1;
         REQ: begin
            if (iresp.addr_ok) begin
               if (iresp.data_ok) begin
                  done     = 1'b1;
                  issue_pt = 1'b1;
               end else begin
                  state_d      = WAIT;
                  ireq_d.valid = 1'b0;
               end
            end
         end
         WAIT: begin
            if (iresp.data_ok) begin
               done     = 1'b1;
               issue_pt = 1'b1;
            end
         end
         default: ;
      endcase

      // A completing response is wrong-path if drop is set or a redirect
      // arrives in the same cycle; either way it is not enqueued.
      if (done) begin
         drop_d = 1'b0;
         if (!drop_q && !redirect_valid) begin
            q_push     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
      end

`ifdef FETCH_ALIGN_CHECK_EN
      if ((state_q == IDLE) && pc_misaligned(fetch_pc_q) && !halt_q &&
          !redirect_valid && (q_count < DEPTH_CNT)) begin
         q_push      = 1'b1;
         q_push_data = '{pc: fetch_pc_q, instr: '0, adel: 1'b1};
         halt_d      = 1'b1;
      end
`endif

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         if ((state_q != IDLE) && !done) drop_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
         halt_d = 1'b0;
`endif
      end

      // Credit is judged on the queue occupancy after this cycle's
      // push/pop/flush, so entries plus the outstanding request never
      // exceed QUEUE_DEPTH.
      if (redirect_valid) begin
         cnt_next = '0;
      end else begin
         cnt_next = q_count;
         if (q_push && !q_pop)      cnt_next = q_count + 1'b1;
         else if (!q_push && q_pop) cnt_next = q_count - 1'b1;
      end

      may_issue = (cnt_next < DEPTH_CNT);
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc_misaligned(fetch_pc_d)) may_issue = 1'b0;
`endif

      if (issue_pt) begin
         if (may_issue) begin
            state_d      = REQ;
            ireq_d.valid = 1'b1;
            ireq_d.addr  = fetch_pc_d;
         end else begin
            state_d      = IDLE;
            ireq_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         drop_q     <= 1'b0;
         ireq_q     <= '{valid: 1'b0, addr: RESET_PC};
`ifdef FETCH_ALIGN_CHECK_EN
         halt_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
         ireq_q     <= ireq_d;
`ifdef FETCH_ALIGN_CHECK_EN
         halt_q     <= halt_d;
`endif
      end
   end

   assign ireq      = ireq_q;
   assign out_valid = q_head_valid;
   assign out_pc    = q_head.pc;
   assign out_instr = q_head.instr;
   assign out_adel  = q_head.adel;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        deq_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_adel;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   fetch_unit #(
      .RESET_PC    (32'hbfc0_0000),
      .QUEUE_DEPTH (4),
      .PC_STEP     (32'd4)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .deq_ready      (deq_ready),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_adel       (out_adel),
      .ireq           (ireq),
      .iresp          (iresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus slave word for a given address.
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h0f0f_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample point is 1ns after the edge; the slave then
   // presents the word belonging to the currently requested address.
   task automatic step();
      @(posedge clk);
      #1;
      iresp.data = instr_of(ireq.addr);
   endtask

   initial begin
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      deq_ready      = 1'b0;
      iresp          = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_adel", out_adel, 1'b0);
      chk("rst_ireq_valid", ireq.valid, 1'b0);
      chk("rst_ireq_addr", ireq.addr, 32'hbfc0_0000);

      // Free-running bus, decode always ready
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = instr_of(32'hbfc0_0000);
      deq_ready     = 1'b1;
      resetn        = 1'b1;
      step();
      chk("fr1_out_valid", out_valid, 1'b0);
      chk("fr1_ireq_valid", ireq.valid, 1'b1);
      chk("fr1_ireq_addr", ireq.addr, 32'hbfc0_0000);
      step();
      chk("fr2_out_valid", out_valid, 1'b1);
      chk("fr2_out_pc", out_pc, 32'hbfc0_0000);
      chk("fr2_out_instr", out_instr, instr_of(32'hbfc0_0000));
      chk("fr2_ireq_addr", ireq.addr, 32'hbfc0_0004);
      step();
      chk("fr3_out_pc", out_pc, 32'hbfc0_0004);
      step();
      chk("fr4_out_pc", out_pc, 32'hbfc0_0008);
      chk("fr4_out_instr", out_instr, instr_of(32'hbfc0_0008));

      // Bus stops; queue drains and the last head value is held
      iresp.addr_ok = 1'b0;
      iresp.data_ok = 1'b0;
      step();
      chk("empty_out_valid", out_valid, 1'b0);
      chk("empty_out_pc_hold", out_pc, 32'hbfc0_0008);
      chk("empty_ireq_valid", ireq.valid, 1'b1);
      chk("empty_ireq_addr", ireq.addr, 32'hbfc0_000c);

      // Decode stall for 10 cycles: queue fills to 4, no further request
      deq_ready     = 1'b0;
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      step();
      chk("stall1_out_pc", out_pc, 32'hbfc0_000c);
      chk("stall1_ireq_addr", ireq.addr, 32'hbfc0_0010);
      step();
      step();
      chk("stall3_ireq_addr", ireq.addr, 32'hbfc0_0018);
      step();
      chk("stall4_ireq_valid", ireq.valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("stall_hold_ireq_valid", ireq.valid, 1'b0);
         chk("stall_hold_out_pc", out_pc, 32'hbfc0_000c);
      end

      // Release: entries drain in order, fetching resumes
      deq_ready = 1'b1;
      step();
      chk("drain1_out_pc", out_pc, 32'hbfc0_0010);
      chk("drain1_ireq_valid", ireq.valid, 1'b1);
      chk("drain1_ireq_addr", ireq.addr, 32'hbfc0_001c);
      step();
      chk("drain2_out_pc", out_pc, 32'hbfc0_0014);
      chk("drain2_ireq_addr", ireq.addr, 32'hbfc0_0020);
      iresp.data_ok = 1'b0;
      step();
      chk("drain3_out_pc", out_pc, 32'hbfc0_0018);
      chk("wait_ireq_valid", ireq.valid, 1'b0);

      // Redirect while in WAIT; the late response must be discarded
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_1000;
      iresp.addr_ok  = 1'b0;
      step();
      chk("rdw_out_valid", out_valid, 1'b0);
      chk("rdw_ireq_valid", ireq.valid, 1'b0);
      redirect_valid = 1'b0;
      step();
      step();
      chk("rdw_wait_ireq_valid", ireq.valid, 1'b0);
      iresp.data_ok = 1'b1;
      iresp.data    = 32'hdead_beef;
      step();
      chk("rdw_drop_out_valid", out_valid, 1'b0);
      chk("rdw_new_ireq_valid", ireq.valid, 1'b1);
      chk("rdw_new_ireq_addr", ireq.addr, 32'h8000_1000);
      iresp.addr_ok = 1'b1;
      step();
      chk("rdw_new_out_pc", out_pc, 32'h8000_1000);
      chk("rdw_new_out_instr", out_instr, instr_of(32'h8000_1000));
      chk("rdw_next_ireq_addr", ireq.addr, 32'h8000_1004);

      // Redirect while in REQ with addr_ok low for 5 cycles
      iresp.addr_ok  = 1'b0;
      iresp.data_ok  = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_2000;
      step();
      chk("rdr_out_valid", out_valid, 1'b0);
      chk("rdr_ireq_valid", ireq.valid, 1'b1);
      chk("rdr_ireq_addr", ireq.addr, 32'h8000_1004);
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rdr_hold_ireq_addr", ireq.addr, 32'h8000_1004);
         chk("rdr_hold_ireq_valid", ireq.valid, 1'b1);
      end
      iresp.addr_ok = 1'b1;
      step();
      chk("rdr_wait_ireq_valid", ireq.valid, 1'b0);
      iresp.addr_ok = 1'b0;
      iresp.data_ok = 1'b1;
      iresp.data    = 32'hdead_beef;
      step();
      chk("rdr_drop_out_valid", out_valid, 1'b0);
      chk("rdr_new_ireq_valid", ireq.valid, 1'b1);
      chk("rdr_new_ireq_addr", ireq.addr, 32'h8000_2000);

      // Fill the queue, then redirect + data_ok + deq_ready together
      deq_ready     = 1'b0;
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      repeat (4) step();
      chk("full_out_valid", out_valid, 1'b1);
      chk("full_out_pc", out_pc, 32'h8000_2000);
      chk("full_ireq_valid", ireq.valid, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_3000;
      deq_ready      = 1'b1;
      step();
      chk("fullrd_out_valid", out_valid, 1'b0);
      chk("fullrd_out_pc_hold", out_pc, 32'h8000_2000);
      chk("fullrd_ireq_valid", ireq.valid, 1'b1);
      chk("fullrd_ireq_addr", ireq.addr, 32'h8000_3000);
      redirect_valid = 1'b0;
      step();
      chk("fullrd_next_out_valid", out_valid, 1'b1);
      chk("fullrd_next_out_pc", out_pc, 32'h8000_3000);
      chk("fullrd_next_out_instr", out_instr, instr_of(32'h8000_3000));

      // Redirect to a misaligned target (response completing this cycle is discarded)
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0002;
      step();
      chk("mis_out_valid", out_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_ireq_valid", ireq.valid, 1'b0);
`else
      chk("mis_ireq_valid", ireq.valid, 1'b1);
      chk("mis_ireq_addr", ireq.addr, 32'h8000_0002);
`endif
      redirect_valid = 1'b0;
      step();
      chk("mis_e_out_valid", out_valid, 1'b1);
      chk("mis_e_out_pc", out_pc, 32'h8000_0002);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_e_out_adel", out_adel, 1'b1);
      chk("mis_e_out_instr", out_instr, 32'h0);
      chk("mis_e_ireq_valid", ireq.valid, 1'b0);
      step();
      chk("mis_halt_out_valid", out_valid, 1'b0);
      chk("mis_halt_ireq_valid", ireq.valid, 1'b0);
`else
      chk("mis_e_out_adel", out_adel, 1'b0);
      chk("mis_e_out_instr", out_instr, instr_of(32'h8000_0002));
      chk("mis_e_ireq_addr", ireq.addr, 32'h8000_0006);
      step();
      chk("mis_next_out_pc", out_pc, 32'h8000_0006);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
